// File: rtl/dark_channel_min3x3.sv
// 3x3 trailing-window minimum (erosion) over the min(R,G,B) stream, 3 clk latency, no backpressure.
// Optional DARK_MIN_FRAME_STATS_EN adds per-frame maximum of post_img (dark_max / dark_max_valid).
module dark_channel_min3x3 #(
    parameter int IMG_WIDTH = 640,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pre_frame_vsync,
    input  logic              pre_frame_href,
    input  logic              pre_frame_clken,
    input  logic [DATA_W-1:0] pre_img,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img
`ifdef DARK_MIN_FRAME_STATS_EN
    ,
    output logic [DATA_W-1:0] dark_max,
    output logic              dark_max_valid
`endif
);

    localparam int                AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [AW-1:0]     COL_LAST = AW'(IMG_WIDTH - 1);
    localparam logic [DATA_W-1:0] PIX_MAX  = '1;

    function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    logic              pix_vld;
    logic              href_q, vsync_q;
    logic              href_fall, vsync_rise;
    logic [AW-1:0]     col_q, col_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        row_q, row_d;

    logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb2_mem [IMG_WIDTH];

    logic              s1_vld_q, s1_r1_q, s1_r2_q;
    logic [DATA_W-1:0] s1_cur_q, s1_lb1_q, s1_lb2_q;
    logic              s2_vld_q;
    logic [DATA_W-1:0] s2_v_q, s2_v_d;
    logic [DATA_W-1:0] h0_q, h1_q, h2_q, h0_eff, h1_eff, s3_min;
    logic              href2_rise;
    logic [DATA_W-1:0] post_img_q;
    logic [2:0]        vs_sr_q, hr_sr_q, ce_sr_q;

    assign pix_vld    = pre_frame_href & pre_frame_clken;
    assign href_fall  = href_q & ~pre_frame_href;
    assign vsync_rise = pre_frame_vsync & ~vsync_q;

    // ovf marks that address IMG_WIDTH-1 is already written this line; later pixels only read.
    always_comb begin
        col_d = col_q;
        ovf_d = ovf_q;
        row_d = row_q;
        if (href_fall) begin
            col_d = '0;
            ovf_d = 1'b0;
        end else if (pix_vld) begin
            if (col_q == COL_LAST) ovf_d = 1'b1;
            else                   col_d = col_q + 1'b1;
        end
        if (vsync_rise)                      row_d = 2'd0;
        else if (href_fall && row_q != 2'd2) row_d = row_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (pix_vld && !ovf_q) begin
            lb2_mem[col_q] <= lb1_mem[col_q];
            lb1_mem[col_q] <= pre_img;
        end
    end

    always_comb begin
        s2_v_d = s1_cur_q;
        if (s1_r1_q) s2_v_d = min2(s2_v_d, s1_lb1_q);
        if (s1_r2_q) s2_v_d = min2(s2_v_d, s1_lb2_q);
    end

    // A new line starts with empty left columns; the preset may coincide with the first shift.
    assign href2_rise = hr_sr_q[1] & ~hr_sr_q[2];
    assign h0_eff     = href2_rise ? PIX_MAX : h0_q;
    assign h1_eff     = href2_rise ? PIX_MAX : h1_q;
    assign s3_min     = min2(s2_v_q, min2(h0_eff, h1_eff));

    always_ff @(posedge clk) begin
        if (rst) begin
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            col_q      <= '0;
            ovf_q      <= 1'b0;
            row_q      <= 2'd0;
            s1_vld_q   <= 1'b0;
            s1_r1_q    <= 1'b0;
            s1_r2_q    <= 1'b0;
            s1_cur_q   <= '0;
            s1_lb1_q   <= '0;
            s1_lb2_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_v_q     <= '0;
            h0_q       <= '0;
            h1_q       <= '0;
            h2_q       <= '0;
            post_img_q <= '0;
            vs_sr_q    <= '0;
            hr_sr_q    <= '0;
            ce_sr_q    <= '0;
        end else begin
            href_q   <= pre_frame_href;
            vsync_q  <= pre_frame_vsync;
            col_q    <= col_d;
            ovf_q    <= ovf_d;
            row_q    <= row_d;
            vs_sr_q  <= {vs_sr_q[1:0], pre_frame_vsync};
            hr_sr_q  <= {hr_sr_q[1:0], pre_frame_href};
            ce_sr_q  <= {ce_sr_q[1:0], pre_frame_clken};
            s1_vld_q <= pix_vld;
            if (pix_vld) begin
                s1_cur_q <= pre_img;
                s1_lb1_q <= lb1_mem[col_q];
                s1_lb2_q <= lb2_mem[col_q];
                s1_r1_q  <= (row_q >= 2'd1);
                s1_r2_q  <= (row_q >= 2'd2);
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) s2_v_q <= s2_v_d;
            if (s2_vld_q) begin
                h0_q       <= s2_v_q;
                h1_q       <= h0_eff;
                h2_q       <= h1_eff;
                post_img_q <= s3_min;
            end else if (href2_rise) begin
                h0_q <= PIX_MAX;
                h1_q <= PIX_MAX;
            end
        end
    end

    assign post_frame_vsync = vs_sr_q[2];
    assign post_frame_href  = hr_sr_q[2];
    assign post_frame_clken = ce_sr_q[2];
    assign post_img         = post_img_q;

`ifdef DARK_MIN_FRAME_STATS_EN
    logic              pvs_rise, pvs_fall;
    logic [DATA_W-1:0] run_q, run_d, dark_max_q;
    logic              dark_max_valid_q;

    // Edges of post_frame_vsync as seen at the clock edge that changes it.
    assign pvs_rise = vs_sr_q[1] & ~vs_sr_q[2];
    assign pvs_fall = vs_sr_q[2] & ~vs_sr_q[1];

    always_comb begin
        run_d = pvs_rise ? '0 : run_q;
        if (s2_vld_q && s3_min > run_d) run_d = s3_min;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q            <= '0;
            dark_max_q       <= '0;
            dark_max_valid_q <= 1'b0;
        end else begin
            run_q            <= run_d;
            dark_max_valid_q <= pvs_fall;
            if (pvs_fall) dark_max_q <= run_q;
        end
    end

    assign dark_max       = dark_max_q;
    assign dark_max_valid = dark_max_valid_q;
`endif

endmodule

// File: tb/tb_dark_channel_min3x3.sv
// Randomized and directed bench for dark_channel_min3x3 against a window-formula reference model.
module tb_dark_channel_min3x3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_nxt = 1'b1;
    logic       pre_frame_vsync = 1'b0, pre_frame_href = 1'b0, pre_frame_clken = 1'b0;
    logic [7:0] pre_img = 8'h00;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic [7:0] post_img;
`ifdef DARK_MIN_FRAME_STATS_EN
    logic [7:0] dark_max;
    logic       dark_max_valid;
`endif

    dark_channel_min3x3 #(.IMG_WIDTH(640), .DATA_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_href   (pre_frame_href),
        .pre_frame_clken  (pre_frame_clken),
        .pre_img          (pre_img),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img         (post_img)
`ifdef DARK_MIN_FRAME_STATS_EN
        ,
        .dark_max         (dark_max),
        .dark_max_valid   (dark_max_valid)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the frame image and the trailing 3x3 minimum with out-of-frame positions as FF.
    logic [7:0] img [0:7][0:15];
    int         cur_row, cur_col;
    logic [7:0] exp_q [$];
    logic [7:0] got [0:255];
    int         got_n;

    function automatic logic [7:0] win_min(input int r, input int c);
        logic [7:0] m = 8'hFF;
        for (int i = r - 2; i <= r; i++)
            for (int j = c - 2; j <= c; j++)
                if (i >= 0 && j >= 0 && img[i][j] < m) m = img[i][j];
        return m;
    endfunction

    // Input history: element k holds what the DUT sampled k clock edges ago.
    typedef struct packed { logic r; logic v; logic h; logic c; } smp_t;
    smp_t hist [3] = '{'{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0}};

    always @(posedge clk) begin
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{rst, pre_frame_vsync, pre_frame_href, pre_frame_clken};
    end

    logic [7:0] hold = 8'h00;
    logic       pvs  = 1'b0;
    logic [7:0] run  = 8'h00;
    logic [7:0] dm   = 8'h00;

    always @(negedge clk) begin
        logic anyr, xv, xh, xc, xdmv;
        anyr = hist[0].r | hist[1].r | hist[2].r;
        xv   = anyr ? 1'b0 : hist[2].v;
        xh   = anyr ? 1'b0 : hist[2].h;
        xc   = anyr ? 1'b0 : hist[2].c;
        check("post_vsync", post_frame_vsync, xv);
        check("post_href", post_frame_href, xh);
        check("post_clken", post_frame_clken, xc);
        xdmv = 1'b0;
        if (hist[0].r) begin
            exp_q.delete();
            hold = 8'h00;
            run  = 8'h00;
            dm   = 8'h00;
        end else begin
            if (xv && !pvs) run = 8'h00;
            if (pvs && !xv) begin
                xdmv = 1'b1;
                dm   = run;
            end
            if (xh && xc) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0h expected none at %0t", post_img, $time);
                end else begin
                    hold = exp_q.pop_front();
                    if (hold > run) run = hold;
                end
                if (got_n < 256) got[got_n] = post_img;
                got_n++;
            end
        end
        pvs = xv;
        check("post_img", post_img, hold);
`ifdef DARK_MIN_FRAME_STATS_EN
        check("dark_max_valid", dark_max_valid, xdmv);
        check("dark_max", dark_max, dm);
`endif
    end

    task automatic drive(input logic v, input logic h, input logic c, input logic [7:0] p);
        @(negedge clk);
        #1;
        rst             = rst_nxt;
        pre_frame_vsync = v;
        pre_frame_href  = h;
        pre_frame_clken = c;
        pre_img         = p;
        if (h && c && !rst_nxt) begin
            exp_q.push_back(win_min(cur_row, cur_col));
            cur_col++;
        end
    endtask

    // gapmode 0: dense, 1: clken low every other clk, 2: random gaps.
    task automatic send_frame(input int h, input int w, input int gapmode);
        got_n = 0;
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int r = 0; r < h; r++) begin
            cur_row = r;
            cur_col = 0;
            for (int c = 0; c < w; c++) begin
                if (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 2) == 0))
                    drive(1'b1, 1'b1, 1'b0, 8'($urandom));
                drive(1'b1, 1'b1, 1'b1, img[r][c]);
            end
            repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00);
        end
        repeat (6) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) img[r][c] = v;
    endtask

    task automatic check_dark_pixel(input string nm);
        check({nm, "_n"}, got_n, 40);
        check({nm, "_r1c3"}, got[1*8+3], 8'h10);
        check({nm, "_r2c4"}, got[2*8+4], 8'h10);
        check({nm, "_r3c5"}, got[3*8+5], 8'h10);
        check({nm, "_r0c3"}, got[0*8+3], 8'hC0);
        check({nm, "_r1c2"}, got[1*8+2], 8'hC0);
        check({nm, "_r1c6"}, got[1*8+6], 8'hC0);
        check({nm, "_r4c4"}, got[4*8+4], 8'hC0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cur_row = 0;
        cur_col = 0;
        got_n   = 0;
        fill(8'hFF);
        // Valid pixels under reset must not reach the outputs.
        repeat (4) drive(1'b0, 1'b1, 1'b1, 8'h55);
        check("reset_img", post_img, 8'h00);
        check("reset_clken", post_frame_clken, 1'b0);
        rst_nxt = 1'b0;
        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);

        fill(8'h80);
        send_frame(4, 8, 0);
        check("flat_n", got_n, 32);
        check("flat_first", got[0], 8'h80);
        check("flat_last", got[31], 8'h80);

        fill(8'hC0);
        img[1][3] = 8'h10;
        send_frame(5, 8, 0);
        check_dark_pixel("dark");

        fill(8'hF0);
        img[0][0] = 8'h20;
        send_frame(4, 8, 0);
        check("tl_r0c0", got[0], 8'h20);
        check("tl_r0c2", got[2], 8'h20);
        check("tl_r2c2", got[2*8+2], 8'h20);
        check("tl_r0c3", got[3], 8'hF0);
        check("tl_r3c0", got[3*8+0], 8'hF0);

        fill(8'hC0);
        img[1][3] = 8'h10;
        send_frame(5, 8, 1);
        check_dark_pixel("gap");

        for (int f = 0; f < 14; f++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
            send_frame($urandom_range(1, 6), $urandom_range(1, 16), $urandom_range(0, 2));
        end

`ifdef DARK_MIN_FRAME_STATS_EN
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom_range(0, 'h99));
        for (int r = 1; r <= 3; r++)
            for (int c = 1; c <= 3; c++) img[r][c] = 8'h9A;
        send_frame(5, 6, 0);
        check("stats_max", dark_max, 8'h9A);
        fill(8'h00);
        send_frame(4, 8, 2);
        check("stats_zero", dark_max, 8'h00);
`endif

        repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("queue_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
